comp_hash_table: RTL and testbench

COMP_HASH_TABLE -- requirements
Module: comp_hash_table

---
 rtl/comp_hash_table.sv | 139 +++++++++++++
 tb/tb_comp_hash_table.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_hash_table.sv
// Hash-chain head table for an LZ-style compressor: hashes 3 input bytes, returns the previous
// position with the same hash and records the current one. Optional stats via COMP_HASH_STATS_EN.
module comp_hash_table #(
  parameter int unsigned TABLE_BITS = 12,
  parameter int unsigned PTR_BITS   = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [23:0]         toHash,
  input  logic [PTR_BITS-1:0] cur_ptr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PTR_BITS-1:0] offset,
  output logic                hit
`ifdef COMP_HASH_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int unsigned Depth = 2 ** TABLE_BITS;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StHash,
    StLookup,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [TABLE_BITS-1:0] clr_idx_q;
  logic [23:0]           data_q;
  logic [PTR_BITS-1:0]   ptr_q;
  logic [TABLE_BITS-1:0] hash_q, hash_d;
  logic [PTR_BITS-1:0]   offset_q;
  logic                  hit_q;

  logic                  tbl_valid [Depth];
  logic [PTR_BITS-1:0]   tbl_ptr   [Depth];

  logic [31:0]           mix;
  logic [31:0]           product;
  logic                  rd_valid;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic                  lookup_hit;

  // Multiplicative hash; the 32-bit product deliberately wraps.
  always_comb begin
    mix     = ({24'd0, data_q[23:16]} << 8) ^ ({24'd0, data_q[15:8]} << 4) ^ {24'd0, data_q[7:0]};
    product = 32'd40543 * mix;
    hash_d  = TABLE_BITS'(product >> 4);
  end

  // Entries at or above the current pointer are stale (pointer wrapped) and count as misses.
  always_comb begin
    rd_valid   = tbl_valid[hash_q];
    rd_ptr     = tbl_ptr[hash_q];
    lookup_hit = rd_valid && (rd_ptr < ptr_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear:  if (clr_idx_q == '1) state_d = StIdle;
      StIdle:   if (req_valid) state_d = StHash;
      StHash:   state_d = StLookup;
      StLookup: state_d = StResp;
      StResp:   if (rsp_ready) state_d = StIdle;
      default:  state_d = StClear;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    offset    = offset_q;
    hit       = hit_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      data_q    <= '0;
      ptr_q     <= '0;
      hash_q    <= '0;
      offset_q  <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StClear) begin
        clr_idx_q <= clr_idx_q + TABLE_BITS'(1);
      end
      if (state_q == StIdle && req_valid) begin
        data_q <= toHash;
        ptr_q  <= cur_ptr;
      end
      if (state_q == StHash) begin
        hash_q <= hash_d;
      end
      if (state_q == StLookup) begin
        hit_q    <= lookup_hit;
        offset_q <= lookup_hit ? rd_ptr : '0;
      end
    end
  end

  // Table storage has no reset of its own; the CLEAR sweep invalidates it entry by entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == StClear) begin
        tbl_valid[clr_idx_q] <= 1'b0;
      end else if (state_q == StLookup) begin
        tbl_valid[hash_q] <= 1'b1;
        tbl_ptr[hash_q]   <= ptr_q;
      end
    end
  end

`ifdef COMP_HASH_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == StResp && rsp_ready) begin
      if (hit_q) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_comp_hash_table.sv
// Directed bench for comp_hash_table: clear timing, hit/miss/stale lookups, stall, throughput,
// reset mid-request, and the optional statistics counters (COMP_HASH_STATS_EN).
module tb_comp_hash_table;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] toHash;
  logic [11:0] cur_ptr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] offset;
  logic        hit;
`ifdef COMP_HASH_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks;
  int failures;

  // Hand-computed table indexes: "abc" -> 2749, "xyz" -> 3645, "qqq" -> 3263.
  localparam logic [23:0] Abc = 24'h616263;
  localparam logic [23:0] Xyz = 24'h78797a;
  localparam logic [23:0] Qqq = 24'h717171;

  comp_hash_table dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .toHash    (toHash),
    .cur_ptr   (cur_ptr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .offset    (offset),
    .hit       (hit)
`ifdef COMP_HASH_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at a negedge; returns at the first RESP negedge (or one cycle later if rsp_ready=1).
  task automatic send(input logic [23:0] d, input logic [11:0] p, output logic h,
                      output logic [11:0] o, output int lat);
    int n;
    n   = 0;
    h   = 1'bx;
    o   = 'x;
    lat = 0;
    while (!req_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL send_accept_timeout req_ready=%b required=1", req_ready);
      return;
    end
    req_valid = 1'b1;
    toHash    = d;
    cur_ptr   = p;
    @(negedge clock);
    req_valid = 1'b0;
    lat       = 1;
    while (!rsp_valid && lat < 32) begin
      @(negedge clock);
      lat++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL send_rsp_timeout rsp_valid=%b required=1", rsp_valid);
      return;
    end
    h = hit;
    o = offset;
    if (rsp_ready) @(negedge clock);
  endtask

  task automatic test_reset;
    int n;
    reset     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    toHash    = '0;
    cur_ptr   = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, hit, offset} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {req_ready, rsp_valid, hit, offset});
    end
    reset = 1'b1;
    n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n !== 4096) begin
      failures++;
      $display("FAIL clear_length cycles=%0d required=4096", n);
    end
  endtask

  task automatic test_first_lookup;
    logic h;
    logic [11:0] o;
    int lat;
    send(Xyz, 12'd7, h, o, lat);
    checks++;
    if ({h, o} !== {1'b0, 12'd0}) begin
      failures++;
      $display("FAIL first_lookup hit=%b offset=%0d required hit=0 offset=0", h, o);
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL latency cycles=%0d required=3", lat);
    end
  endtask

  task automatic test_hit;
    logic h;
    logic [11:0] o;
    int lat;
    send(Abc, 12'd5, h, o, lat);
    checks++;
    if ({h, o} !== {1'b0, 12'd0}) begin
      failures++;
      $display("FAIL hit_abc5 hit=%b offset=%0d required hit=0 offset=0", h, o);
    end
    send(Abc, 12'd20, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd5}) begin
      failures++;
      $display("FAIL hit_abc20 hit=%b offset=%0d required hit=1 offset=5", h, o);
    end
    send(Abc, 12'd25, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd20}) begin
      failures++;
      $display("FAIL hit_abc25 hit=%b offset=%0d required hit=1 offset=20", h, o);
    end
  endtask

  task automatic test_stale;
    logic h;
    logic [11:0] o;
    int lat;
    send(Abc, 12'd30, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd25}) begin
      failures++;
      $display("FAIL stale_abc30 hit=%b offset=%0d required hit=1 offset=25", h, o);
    end
    send(Abc, 12'd10, h, o, lat);
    checks++;
    if ({h, o} !== {1'b0, 12'd0}) begin
      failures++;
      $display("FAIL stale_abc10 hit=%b offset=%0d required hit=0 offset=0", h, o);
    end
    send(Abc, 12'd12, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd10}) begin
      failures++;
      $display("FAIL stale_abc12 hit=%b offset=%0d required hit=1 offset=10", h, o);
    end
    // Equal pointer is not strictly older.
    send(Abc, 12'd12, h, o, lat);
    checks++;
    if ({h, o} !== {1'b0, 12'd0}) begin
      failures++;
      $display("FAIL stale_equal hit=%b offset=%0d required hit=0 offset=0", h, o);
    end
  endtask

  task automatic test_isolation;
    logic h;
    logic [11:0] o;
    int lat;
    send(Xyz, 12'd40, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd7}) begin
      failures++;
      $display("FAIL isolation_xyz40 hit=%b offset=%0d required hit=1 offset=7", h, o);
    end
  endtask

  task automatic test_back_to_back;
    int acc;
    int rsps;
    acc  = 0;
    rsps = 0;
    req_valid = 1'b1;
    toHash    = Qqq;
    cur_ptr   = 12'd0;
    for (int i = 0; i < 16; i++) begin
      if (req_ready) acc++;
      if (rsp_valid) rsps++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    checks++;
    if (acc !== 4) begin
      failures++;
      $display("FAIL b2b_accepts count=%0d required=4", acc);
    end
    checks++;
    if (rsps !== 4) begin
      failures++;
      $display("FAIL b2b_responses count=%0d required=4", rsps);
    end
  endtask

  task automatic test_stall;
    logic h;
    logic [11:0] o;
    int lat;
    rsp_ready = 1'b0;
    send(Abc, 12'd50, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd12}) begin
      failures++;
      $display("FAIL stall_first hit=%b offset=%0d required hit=1 offset=12", h, o);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++;
      if ({rsp_valid, req_ready, hit, offset} !== {1'b1, 1'b0, 1'b1, 12'd12}) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d valid=%b ready=%b hit=%b offset=%0d required 1 0 1 12",
                 i, rsp_valid, req_ready, hit, offset);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL stall_release valid=%b ready=%b required valid=0 ready=1", rsp_valid,
               req_ready);
    end
  endtask

  task automatic test_reset_in_lookup;
    int n;
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL rst_lookup_idle req_ready=%b required=1", req_ready);
    end
    req_valid = 1'b1;
    toHash    = Abc;
    cur_ptr   = 12'd60;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({rsp_valid, req_ready, hit, offset} !== 15'd0) begin
      failures++;
      $display("FAIL rst_lookup_outputs got=%h required=0", {rsp_valid, req_ready, hit, offset});
    end
    reset = 1'b1;
    n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n !== 4096) begin
      failures++;
      $display("FAIL rst_lookup_clear cycles=%0d required=4096", n);
    end
  endtask

  task automatic test_after_reset;
    logic h;
    logic [11:0] o;
    int lat;
    send(Abc, 12'd100, h, o, lat);
    checks++;
    if ({h, o} !== {1'b0, 12'd0}) begin
      failures++;
      $display("FAIL cleared_abc hit=%b offset=%0d required hit=0 offset=0", h, o);
    end
    send(Xyz, 12'd100, h, o, lat);
    checks++;
    if ({h, o} !== {1'b0, 12'd0}) begin
      failures++;
      $display("FAIL cleared_xyz hit=%b offset=%0d required hit=0 offset=0", h, o);
    end
    send(Abc, 12'd110, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd100}) begin
      failures++;
      $display("FAIL post_abc110 hit=%b offset=%0d required hit=1 offset=100", h, o);
    end
    send(Abc, 12'd120, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd110}) begin
      failures++;
      $display("FAIL post_abc120 hit=%b offset=%0d required hit=1 offset=110", h, o);
    end
    send(Xyz, 12'd130, h, o, lat);
    checks++;
    if ({h, o} !== {1'b1, 12'd100}) begin
      failures++;
      $display("FAIL post_xyz130 hit=%b offset=%0d required hit=1 offset=100", h, o);
    end
  endtask

`ifdef COMP_HASH_STATS_EN
  task automatic test_stats;
    checks++;
    if ({hit_count, miss_count} !== {32'd3, 32'd2}) begin
      failures++;
      $display("FAIL stats hit_count=%0d miss_count=%0d required 3 2", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_first_lookup();
    test_hit();
    test_stale();
    test_isolation();
    test_back_to_back();
    test_stall();
    test_reset_in_lookup();
    test_after_reset();
`ifdef COMP_HASH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
